branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
- Sequences control-flow resolution in the execute stage.
- Consumes the branch comparator's taken flag and execute-stage opcode/target, and decides on a PC redirect.
- Holds the redirect until fetch accepts it, then squashes wrong-path instructions for a programmable drain window.
- Keeps saturating branch/jump statistics for performance analysis.

Parameters:
DRAIN_CYCLES, 1, cycles of flush_de after fetch accepts the redirect (0 allowed).
STAT_W, 32, width of each statistics counter.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
e_valid  in  1  execute stage holds a real instruction
e_opcode  in  7  execute-stage opcode
e_br_taken  in  1  comparator result for the execute-stage branch
e_target  in  32  computed branch/jump target
stall  in  1  hazard unit freezes execute this cycle
f_ready  in  1  fetch samples pc_target this cycle
clear_stats  in  1  synchronous clear of statistics counters
pc_redirect  out  1  fetch must load pc_target
pc_target  out  32  registered redirect address, bits [1:0] forced to 0
flush_fd  out  1  squash IF/ID register
flush_de  out  1  squash ID/EX register
target_misaligned  out  1  sticky: a redirect target had bits [1:0] != 0
br_count  out  STAT_W  branches resolved
br_taken_count  out  STAT_W  taken branches
jump_count  out  STAT_W  JAL/JALR resolved

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0, including pc_target, counters and target_misaligned. Drain counter 0. Reset mid-REDIRECT/DRAIN aborts immediately; no redirect survives reset.
- Resolve event: state==IDLE and e_valid=1 and stall=0.
  - take = (opcode 1100011 and e_br_taken) or opcode 1101111 (JAL) or opcode 1100111 (JALR).
  - Any other opcode never redirects; e_br_taken is ignored for it.
- IDLE: outputs pc_redirect, flush_fd, flush_de = 0.
  - On a resolve event with take=1 at edge N: pc_target <= {e_target[31:2],2'b00}. If e_target[1:0]!=0, set target_misaligned. Go to REDIRECT.
  - Redirect latency: pc_redirect is high in cycle N+1.
- REDIRECT: pc_redirect=1, flush_fd=1, flush_de=1. pc_target is held stable.
  - e_valid, e_opcode and e_br_taken are ignored (wrong path). stall is ignored.
  - When f_ready=1: if DRAIN_CYCLES==0, go to IDLE; else load drain counter with DRAIN_CYCLES-1 and go to DRAIN.
  - f_ready=1 in the first REDIRECT cycle gives a one-cycle pulse.
- DRAIN: pc_redirect=0, flush_fd=0, flush_de=1. Execute inputs are ignored.
  - Drain counter decrements each cycle; when it is 0, go to IDLE.
  - A new resolve is possible in the first IDLE cycle.
- Statistics: updated only on resolve events, in the same edge as the event.
  - br_count increments for every branch opcode.
  - br_taken_count increments when a branch opcode is taken.
  - jump_count increments for JAL/JALR.
  - All counters saturate at all-ones, no wrap.
  - clear_stats zeroes all counters and target_misaligned. It wins over a same-cycle increment, so the counter reads 0 after that edge.
- stall=1 in IDLE: no event, no count, no state change, even if the execute inputs qualify.
- Outputs are registered or decoded from state only. There is no combinational path from the inputs to the outputs.

Decomposition:
- Shared package holds:
  - opcode constants OP_BRANCH=7'b1100011, OP_JAL=7'b1101111, OP_JALR=7'b1100111 (shared with decode and the comparator);
  - state enum {IDLE, REDIRECT, DRAIN}.
- Sub-module sat_stat_counter (STAT_W; inc, clr, async active-low reset) is instantiated three times.

Test Plan:
- BEQ event with e_br_taken=1, e_target=0x0100_0040, f_ready=1 at N+1 -> pc_redirect=1 and pc_target=0x0100_0040 for exactly cycle N+1; flush_fd=flush_de=1 at N+1; flush_de only at N+2; IDLE at N+3; br_count=1, br_taken_count=1.
- BNE not taken (e_br_taken=0), then JALR to 0x0100_0102 -> no redirect for BNE; JALR redirects to 0x0100_0100 with target_misaligned=1; br_count=1, br_taken_count=0, jump_count=1.
- Taken branch with f_ready held 0 for 4 cycles -> pc_redirect, flush_fd, flush_de and pc_target stable for 5 cycles; a qualifying JAL presented during REDIRECT is not counted and does not change pc_target.
- Qualifying taken branch with stall=1 for 3 cycles, then stall=0 -> redirect begins only the cycle after stall drops; counted once.
- STAT_W=4, 16 taken branches with clear_stats=1 on the 16th -> counters saturate at 15, then read 0 after the clear edge.
- reset_n=0 asserted mid-REDIRECT, asynchronously between clock edges -> all outputs 0 immediately; after release, IDLE with no pending redirect.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared control-flow definitions: the opcodes that can redirect the PC and the
// states of the execute-stage redirect sequencer.
package branch_redirect_ctrl_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    DRAIN
  } state_e;

  function automatic logic is_jump(input logic [6:0] opcode);
    return (opcode == OP_JAL) || (opcode == OP_JALR);
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_sat_stat_counter.sv
// Saturating statistics counter: sticks at all-ones instead of wrapping, and a
// synchronous clear takes priority over a same-cycle increment.
module sat_stat_counter #(
  parameter int unsigned STAT_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              inc,
  input  logic              clr,
  output logic [STAT_W-1:0] count
);

  logic [STAT_W-1:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + STAT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Execute-stage redirect sequencer: resolves taken branches/jumps, holds the PC
// redirect until fetch accepts it, then squashes ID/EX for a drain window.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 1,
  parameter int unsigned STAT_W       = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              e_valid,
  input  logic [6:0]        e_opcode,
  input  logic              e_br_taken,
  input  logic [31:0]       e_target,
  input  logic              stall,
  input  logic              f_ready,
  input  logic              clear_stats,
  output logic              pc_redirect,
  output logic [31:0]       pc_target,
  output logic              flush_fd,
  output logic              flush_de,
  output logic              target_misaligned,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] br_taken_count,
  output logic [STAT_W-1:0] jump_count
);

  // The counter only ever holds DRAIN_CYCLES-1 down to 0.
  localparam int unsigned    CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  drainCnt_q, drainCnt_d;
  logic [31:0]       pcTarget_q, pcTarget_d;
  logic              misaligned_q, misaligned_d;

  logic resolve;
  logic isBranch;
  logic isJump;
  logic take;

  always_comb begin
    resolve      = (state_q == IDLE) && e_valid && !stall;
    isBranch     = (e_opcode == OP_BRANCH);
    isJump       = is_jump(e_opcode);
    take         = (isBranch && e_br_taken) || isJump;
    state_d      = state_q;
    drainCnt_d   = drainCnt_q;
    pcTarget_d   = pcTarget_q;
    misaligned_d = misaligned_q;

    unique case (state_q)
      IDLE: begin
        if (resolve && take) begin
          state_d    = REDIRECT;
          pcTarget_d = {e_target[31:2], 2'b00};
          if (e_target[1:0] != 2'b00) begin
            misaligned_d = 1'b1;
          end
        end
      end
      REDIRECT: begin
        if (f_ready) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d    = DRAIN;
            drainCnt_d = DRAIN_LOAD;
          end
        end
      end
      DRAIN: begin
        if (drainCnt_q == '0) begin
          state_d = IDLE;
        end else begin
          drainCnt_d = drainCnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_stats) begin
      misaligned_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      drainCnt_q   <= '0;
      pcTarget_q   <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drainCnt_q   <= drainCnt_d;
      pcTarget_q   <= pcTarget_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc_redirect       = (state_q == REDIRECT);
  assign flush_fd          = (state_q == REDIRECT);
  assign flush_de          = (state_q == REDIRECT) || (state_q == DRAIN);
  assign pc_target         = pcTarget_q;
  assign target_misaligned = misaligned_q;

  sat_stat_counter #(.STAT_W(STAT_W)) uBrCount (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (resolve && isBranch),
    .clr     (clear_stats),
    .count   (br_count)
  );

  sat_stat_counter #(.STAT_W(STAT_W)) uBrTakenCount (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (resolve && isBranch && e_br_taken),
    .clr     (clear_stats),
    .count   (br_taken_count)
  );

  sat_stat_counter #(.STAT_W(STAT_W)) uJumpCount (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (resolve && isJump),
    .clr     (clear_stats),
    .count   (jump_count)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: two instances (1-cycle drain / 32-bit stats and
// no drain / 4-bit stats) driven in lockstep and compared against a queue-free
// behavioural model, plus a directed vector table and multi-cycle sequences.
module tb_branch_redirect_ctrl;

  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ADD  = 7'b0110011;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        eValid, eBrTaken, stall, fReady, clearStats;
  logic [6:0]  eOpcode;
  logic [31:0] eTarget;

  logic        aRed, aFd, aDe, aMis, bRed, bFd, bDe, bMis;
  logic [31:0] aTgt, bTgt, aBr, aBrt, aJmp;
  logic [3:0]  bBr, bBrt, bJmp;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  branch_redirect_ctrl #(.DRAIN_CYCLES(1), .STAT_W(32)) dutA (
    .clock(clock), .reset_n(reset_n), .e_valid(eValid), .e_opcode(eOpcode),
    .e_br_taken(eBrTaken), .e_target(eTarget), .stall(stall), .f_ready(fReady),
    .clear_stats(clearStats), .pc_redirect(aRed), .pc_target(aTgt), .flush_fd(aFd),
    .flush_de(aDe), .target_misaligned(aMis), .br_count(aBr),
    .br_taken_count(aBrt), .jump_count(aJmp)
  );

  branch_redirect_ctrl #(.DRAIN_CYCLES(0), .STAT_W(4)) dutB (
    .clock(clock), .reset_n(reset_n), .e_valid(eValid), .e_opcode(eOpcode),
    .e_br_taken(eBrTaken), .e_target(eTarget), .stall(stall), .f_ready(fReady),
    .clear_stats(clearStats), .pc_redirect(bRed), .pc_target(bTgt), .flush_fd(bFd),
    .flush_de(bDe), .target_misaligned(bMis), .br_count(bBr),
    .br_taken_count(bBrt), .jump_count(bJmp)
  );

  // Model: a pending-redirect flag plus a count of drain cycles still owed.
  int          drainCfg[2] = '{1, 0};
  longint      statMax[2]  = '{64'hFFFF_FFFF, 15};
  bit          mPend[2];
  int          mDrainLeft[2];
  logic [31:0] mTarget[2];
  bit          mMis[2];
  longint      mBr[2], mBrt[2], mJmp[2];

  function automatic longint satInc(input longint v, input longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mPend[k] = 0; mDrainLeft[k] = 0; mTarget[k] = '0; mMis[k] = 0;
      mBr[k] = 0; mBrt[k] = 0; mJmp[k] = 0;
    end
  endtask

  task automatic modelStep();
    logic isBr, isJ;
    isBr = (eOpcode == BR);
    isJ  = (eOpcode == JAL) || (eOpcode == JALR);
    for (int k = 0; k < 2; k++) begin
      if (mPend[k]) begin
        if (fReady) begin
          mPend[k] = 0;
          mDrainLeft[k] = drainCfg[k];
        end
      end else if (mDrainLeft[k] > 0) begin
        mDrainLeft[k]--;
      end else if (eValid && !stall) begin
        if (isBr) mBr[k] = satInc(mBr[k], statMax[k]);
        if (isBr && eBrTaken) mBrt[k] = satInc(mBrt[k], statMax[k]);
        if (isJ) mJmp[k] = satInc(mJmp[k], statMax[k]);
        if ((isBr && eBrTaken) || isJ) begin
          mPend[k] = 1;
          mTarget[k] = eTarget & 32'hFFFF_FFFC;
          if (eTarget % 4 != 0) mMis[k] = 1;
        end
      end
      if (clearStats) begin
        mBr[k] = 0; mBrt[k] = 0; mJmp[k] = 0; mMis[k] = 0;
      end
    end
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkInst(input string p, input int k, input logic red, input logic fd,
                           input logic de, input logic [31:0] tgt, input logic mis,
                           input logic [63:0] br, input logic [63:0] brt, input logic [63:0] jmp);
    logic expDe;
    expDe = mPend[k] || (mDrainLeft[k] > 0);
    cmp({p, "pc_redirect"}, 64'(red), 64'(mPend[k]));
    cmp({p, "flush_fd"}, 64'(fd), 64'(mPend[k]));
    cmp({p, "flush_de"}, 64'(de), 64'(expDe));
    cmp({p, "pc_target"}, 64'(tgt), 64'(mTarget[k]));
    cmp({p, "target_misaligned"}, 64'(mis), 64'(mMis[k]));
    cmp({p, "br_count"}, br, 64'(mBr[k]));
    cmp({p, "br_taken_count"}, brt, 64'(mBrt[k]));
    cmp({p, "jump_count"}, jmp, 64'(mJmp[k]));
  endtask

  task automatic checkOutput();
    checkInst("A.", 0, aRed, aFd, aDe, aTgt, aMis, 64'(aBr), 64'(aBrt), 64'(aJmp));
    checkInst("B.", 1, bRed, bFd, bDe, bTgt, bMis, 64'(bBr), 64'(bBrt), 64'(bJmp));
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic tk,
                               input logic [31:0] tgt, input logic st, input logic fr,
                               input logic clr);
    eValid = v; eOpcode = op; eBrTaken = tk; eTarget = tgt;
    stall = st; fReady = fr; clearStats = clr;
    @(posedge clock);
    if (reset_n) modelStep();
    else modelReset();
    #1;
    checkOutput();
  endtask

  typedef struct {
    logic v; logic [6:0] op; logic tk; logic [31:0] tgt; logic st; logic fr; logic clr;
    logic xRed; logic xFd; logic xDe; logic [31:0] xTgt; logic xMis;
    int xBr; int xBrt; int xJmp;
  } vec_t;

  vec_t vecs[12];
  int   redirCycles;

  initial begin
    vecs[0]  = '{1, BR,   1, 32'h0100_0040, 0, 0, 0, 1, 1, 1, 32'h0100_0040, 0, 1, 1, 0};
    vecs[1]  = '{0, 7'h0, 0, 32'h0,         0, 1, 0, 0, 0, 1, 32'h0100_0040, 0, 1, 1, 0};
    vecs[2]  = '{0, 7'h0, 0, 32'h0,         0, 0, 1, 0, 0, 0, 32'h0100_0040, 0, 0, 0, 0};
    vecs[3]  = '{1, BR,   0, 32'h0000_0800, 0, 0, 0, 0, 0, 0, 32'h0100_0040, 0, 1, 0, 0};
    vecs[4]  = '{1, JALR, 0, 32'h0100_0102, 0, 0, 0, 1, 1, 1, 32'h0100_0100, 1, 1, 0, 1};
    vecs[5]  = '{0, 7'h0, 0, 32'h0,         0, 1, 0, 0, 0, 1, 32'h0100_0100, 1, 1, 0, 1};
    vecs[6]  = '{0, 7'h0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0100_0100, 1, 1, 0, 1};
    vecs[7]  = '{1, ADD,  1, 32'h0000_0444, 0, 0, 0, 0, 0, 0, 32'h0100_0100, 1, 1, 0, 1};
    vecs[8]  = '{1, JAL,  0, 32'h0000_2000, 1, 0, 0, 0, 0, 0, 32'h0100_0100, 1, 1, 0, 1};
    vecs[9]  = '{1, JAL,  0, 32'h0000_2000, 0, 0, 0, 1, 1, 1, 32'h0000_2000, 1, 1, 0, 2};
    vecs[10] = '{0, 7'h0, 0, 32'h0,         0, 1, 0, 0, 0, 1, 32'h0000_2000, 1, 1, 0, 2};
    vecs[11] = '{0, 7'h0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0000_2000, 1, 1, 0, 2};

    eValid = 0; eOpcode = '0; eBrTaken = 0; eTarget = '0;
    stall = 0; fReady = 0; clearStats = 0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    checkOutput();
    reset_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].v, vecs[i].op, vecs[i].tk, vecs[i].tgt, vecs[i].st,
                    vecs[i].fr, vecs[i].clr);
      cmp($sformatf("tbl%0d.pc_redirect", i), 64'(aRed), 64'(vecs[i].xRed));
      cmp($sformatf("tbl%0d.flush_fd", i), 64'(aFd), 64'(vecs[i].xFd));
      cmp($sformatf("tbl%0d.flush_de", i), 64'(aDe), 64'(vecs[i].xDe));
      cmp($sformatf("tbl%0d.pc_target", i), 64'(aTgt), 64'(vecs[i].xTgt));
      cmp($sformatf("tbl%0d.misaligned", i), 64'(aMis), 64'(vecs[i].xMis));
      cmp($sformatf("tbl%0d.br_count", i), 64'(aBr), 64'(vecs[i].xBr));
      cmp($sformatf("tbl%0d.br_taken_count", i), 64'(aBrt), 64'(vecs[i].xBrt));
      cmp($sformatf("tbl%0d.jump_count", i), 64'(aJmp), 64'(vecs[i].xJmp));
    end

    $display("[TB] redirect held while fetch is not ready");
    applyStimulus(1, BR, 1, 32'h0000_1230, 0, 0, 0);
    redirCycles = int'(aRed);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, JAL, 0, 32'h0000_4440, 1, 0, 0);
      redirCycles += int'(aRed);
      cmp("hold_target", 64'(aTgt), 64'h1230);
    end
    cmp("hold_redirect_cycles", 64'(redirCycles), 64'd5);
    cmp("hold_jump_uncounted", 64'(aJmp), 64'd2);
    applyStimulus(0, 7'h0, 0, 32'h0, 0, 1, 0);
    applyStimulus(0, 7'h0, 0, 32'h0, 0, 0, 0);

    $display("[TB] stall blocks resolution");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, BR, 1, 32'h0000_3000, 1, 0, 0);
      cmp("stall_no_redirect", 64'(aRed), 64'd0);
    end
    applyStimulus(1, BR, 1, 32'h0000_3000, 0, 0, 0);
    cmp("stall_release_redirect", 64'(aRed), 64'd1);
    cmp("stall_counted_once", 64'(aBr), 64'd3);
    applyStimulus(0, 7'h0, 0, 32'h0, 0, 1, 0);
    applyStimulus(0, 7'h0, 0, 32'h0, 0, 0, 0);

    $display("[TB] saturation and clear priority");
    applyStimulus(0, 7'h0, 0, 32'h0, 0, 0, 1);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, BR, 1, 32'h0000_0104 + 32'(i * 16), 0, 0, (i == 16));
      applyStimulus(0, 7'h0, 0, 32'h0, 0, 1, 0);
      applyStimulus(0, 7'h0, 0, 32'h0, 0, 0, 0);
      applyStimulus(0, 7'h0, 0, 32'h0, 0, 0, 0);
      if (i == 15) begin
        cmp("sat_br_count", 64'(bBr), 64'd15);
        cmp("sat_br_taken_count", 64'(bBrt), 64'd15);
        cmp("nosat_br_count", 64'(aBr), 64'd16);
      end
    end
    cmp("clear_br_count", 64'(bBr), 64'd0);
    cmp("clear_br_taken_count", 64'(bBrt), 64'd0);

    $display("[TB] asynchronous reset mid-redirect");
    applyStimulus(1, JAL, 0, 32'h0000_5000, 0, 0, 0);
    cmp("pre_reset_redirect", 64'(aRed), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    applyStimulus(0, 7'h0, 0, 32'h0, 0, 1, 0);
    reset_n = 1'b1;
    applyStimulus(0, 7'h0, 0, 32'h0, 0, 0, 0);
    cmp("post_reset_no_redirect", 64'(aRed), 64'd0);
    cmp("post_reset_target", 64'(aTgt), 64'd0);

    $display("[TB] randomized run against model");
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] op;
      case ($urandom_range(0, 3))
        0: op = BR;
        1: op = JAL;
        2: op = JALR;
        default: op = 7'($urandom);
      endcase
      applyStimulus($urandom_range(0, 9) < 7, op, 1'($urandom), $urandom,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 4,
                    $urandom_range(0, 99) < 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
